// File: rtl/popo_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
package popo_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/inst_mem_responder_fetch_pipe.sv
// Valid/data shift register of configurable depth. The payload only moves
// along with a valid bit, so the last stage keeps the last delivered word.
module fetch_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // A clear kills every stage and freezes the payload, so no word leaks out.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = '0;
    end else begin
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: preloadable word array served to the core's
// fetch port with a fixed response latency, faults returning a NOP.
module inst_mem_responder
  import popo_pkg::*;
#(
  parameter int                    INST_WIDTH      = INST_W,
  parameter int                    INST_ADDR_WIDTH = ADDR_W,
  parameter int                    DEPTH_LOG2      = 8,
  parameter int                    LATENCY         = 2,
  parameter logic [INST_WIDTH-1:0] NOP_INST        = RV32_NOP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       load_en,
  input  logic [DEPTH_LOG2-1:0]      load_addr,
  input  logic [INST_WIDTH-1:0]      load_data,
  input  logic                       req_valid,
  input  logic [INST_ADDR_WIDTH-1:0] req_addr,
  output logic                       req_ready,
  input  logic                       flush,
  output logic [INST_WIDTH-1:0]      fetch_inst,
  output logic                       inst_valid,
  output logic                       inst_fault,
  output logic [31:0]                resp_count
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  state_e state_q, state_d;
  logic [31:0] resp_count_q, resp_count_d;
  logic [INST_WIDTH-1:0] mem_q [WORDS];

  logic                  accept;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  addr_fault;
  logic [INST_WIDTH-1:0] rd_word;
  logic                  pipe_valid;
  logic [INST_WIDTH:0]   pipe_data;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_count_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_count_q <= resp_count_d;
    end
  end

  // The array has no reset so a preloaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == IDLE && load_en) mem_q[load_addr] <= load_data;
  end

  always_comb begin
    req_ready  = (state_q == RUN) && !flush;
    accept     = req_valid && req_ready;
    word_idx   = req_addr[DEPTH_LOG2+1:2];
    addr_fault = (req_addr[1:0] != 2'b00) ||
                 (req_addr[INST_ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);
    rd_word    = addr_fault ? NOP_INST : mem_q[word_idx];
  end

  fetch_pipe #(
    .DEPTH(LATENCY),
    .WIDTH(INST_WIDTH + 1)
  ) u_fetch_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .in_valid (accept),
    .in_data  ({addr_fault, rd_word}),
    .out_valid(pipe_valid),
    .out_data (pipe_data)
  );

  always_comb begin
    inst_valid   = pipe_valid;
    fetch_inst   = pipe_data[INST_WIDTH-1:0];
    inst_fault   = pipe_valid && pipe_data[INST_WIDTH];
    resp_count_d = resp_count_q + {31'b0, pipe_valid};
    resp_count   = resp_count_q;
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomised bench for inst_mem_responder against a queue-based fetch model.
module tb_inst_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic [31:0] fetch_inst;
  logic        inst_valid;
  logic        inst_fault;
  logic [31:0] resp_count;

  inst_mem_responder #(
    .INST_WIDTH     (32),
    .INST_ADDR_WIDTH(32),
    .DEPTH_LOG2     (8),
    .LATENCY        (LAT),
    .NOP_INST       (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .fetch_inst(fetch_inst),
    .inst_valid(inst_valid),
    .inst_fault(inst_fault),
    .resp_count(resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] word;
    logic        fault;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] ref_mem [256];
  logic        running;
  logic        prev_pulse;
  logic [31:0] last_word;
  logic [31:0] exp_count;
  int          edge_idx;
  int          tests;
  int          fails;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_idx);
    end
  endtask

  // One clock of stimulus with the model advanced at the same edge.
  task automatic applyStimulus(input logic st, input logic ld, input logic [7:0] la,
                               input logic [31:0] ldat, input logic rv,
                               input logic [31:0] ra, input logic fl);
    resp_t r;
    logic  pulse;
    logic  pfault;
    start     = st;
    load_en   = ld;
    load_addr = la;
    load_data = ldat;
    req_valid = rv;
    req_addr  = ra;
    flush     = fl;
    #1;
    checkOutput("req_ready", {31'b0, req_ready}, {31'b0, running && !fl});
    @(posedge clk);
    edge_idx++;
    if (!rst_n) begin
      pend.delete();
      running    = 1'b0;
      last_word  = '0;
      exp_count  = '0;
      prev_pulse = 1'b0;
    end else begin
      if (prev_pulse) exp_count++;
      if (fl) begin
        pend.delete();
      end else if (running && rv) begin
        r.due   = edge_idx + LAT - 1;
        r.fault = (ra[1:0] != 2'b00) || (ra[31:10] != 22'd0);
        r.word  = r.fault ? 32'h0000_0013 : ref_mem[ra[9:2]];
        pend.push_back(r);
      end
      if (!running && ld) ref_mem[la] = ldat;
      if (st) running = 1'b1;
    end
    #1;
    pulse  = (pend.size() > 0) && (pend[0].due == edge_idx);
    pfault = 1'b0;
    if (pulse) begin
      last_word = pend[0].word;
      pfault    = pend[0].fault;
      void'(pend.pop_front());
    end
    checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, pulse});
    checkOutput("fetch_inst", fetch_inst, last_word);
    checkOutput("inst_fault", {31'b0, inst_fault}, {31'b0, pfault});
    checkOutput("resp_count", resp_count, exp_count);
    prev_pulse = pulse;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] a);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, a, 1'b0);
  endtask

  initial begin
    int          kind;
    logic [31:0] a;
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;
    tests = 0;
    fails = 0;
    edge_idx = 0;
    running = 1'b0;
    prev_pulse = 1'b0;
    last_word = '0;
    exp_count = '0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b1, 8'(i), $urandom, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'(i), prog[i], 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    fetch(32'h0);
    idle(3);
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle(3);
    fetch(32'h6); fetch(32'h400);
    idle(3);
    fetch(32'h0); fetch(32'h4);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 32'h8, 1'b1);
    fetch(32'h8);
    idle(3);
    applyStimulus(1'b0, 1'b1, 8'd0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    fetch(32'h0);
    idle(3);
    fetch(32'h0); fetch(32'h4);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    fetch(32'h0); fetch(32'h8);
    idle(2);
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    fetch(32'h4);
    idle(3);

    for (int n = 0; n < 1500; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      a = {22'd0, 8'($urandom), 2'b00};
      else if (kind < 8) a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      else               a = $urandom | 32'h0000_0400;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end else if (running) begin
        applyStimulus(1'b0, $urandom_range(0, 9) == 0, 8'($urandom), $urandom,
                      $urandom_range(0, 9) < 7, a, $urandom_range(0, 99) < 8);
      end else begin
        applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                      $urandom, $urandom_range(0, 1) == 1, a, 1'b0);
      end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
